des_key_schedule_bidir: RTL and testbench
=========================================

Name: des_key_schedule_bidir

Overview:
Sequential DES subkey generator. Produces the sixteen 48-bit round subkeys one per handshake:
- encrypt order: K1..K16, using left rotations;
- decrypt order: K16..K1, using right rotations.

It feeds the iterative round datapath, which holds the f-function (E-expansion, S-boxes, P-box). It is the inverse-direction counterpart needed so the same datapath can decrypt, including the E-D-E legs of 3DES.

Parameters:
- NUM_ROUNDS, 16, subkeys per key load. Fixed by DES; exposed only for the bench.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  synchronous active-low reset
- key_in  input  [0:63]  DES key, MSB-first bit numbering; bits 7,15,..,63 are parity and are ignored
- decrypt  input  1  sampled with key_load: 0 = encrypt order, 1 = decrypt order
- key_load  input  1  load request; accepted only when load_ready=1
- load_ready  output  1  high in IDLE
- subkey  output  [0:47]  current round subkey (PC-2 output)
- subkey_valid  output  1  subkey is valid
- subkey_ready  input  1  consumer accepts subkey when subkey_valid & subkey_ready
- round_idx  output  [3:0]  DES round number minus 1 of the presented subkey (encrypt 0..15, decrypt 15..0)
- last_subkey  output  1  high with the 16th subkey of a sequence

Behaviour:
- Reset: synchronous, evaluated on the clk edge while n_rst=0.
  - State goes to IDLE.
  - Outputs after reset: load_ready=1, subkey_valid=0, last_subkey=0, round_idx=0, subkey=0.
  - C/D registers clear to 0; the latched mode clears to 0.
  - Reset mid-sequence abandons the sequence; no further subkeys are emitted.
- States: IDLE, RUN.
- IDLE → RUN on key_load & load_ready.
  - C,D ← PC-1(key_in) (C = first 28 bits, D = last 28 bits). Latch mode ← decrypt.
  - Encrypt: first presented key state = C,D each rotated left by SHIFT[0]=1; round_idx=0.
  - Decrypt: first presented key state = C0,D0 unrotated (equals C16,D16, since total rotation is 28); round_idx=15.
  - subkey_valid=1 on the cycle after acceptance; latency 1 clock.
- RUN, on a handshake with last_subkey=0: advance to the next key state and round counter.
  - Encrypt: rotate C,D left by SHIFT[round_idx+1], round_idx+1.
  - Decrypt: rotate C,D right by SHIFT[round_idx], round_idx-1.
- SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Rotations are within each 28-bit half independently.
- subkey = PC-2(C,D), registered.
- Backpressure: while subkey_valid & !subkey_ready, subkey, round_idx and last_subkey hold stable.
- Throughput: one subkey per cycle while subkey_ready=1.
- last_subkey=1 when round_idx=15 in encrypt or round_idx=0 in decrypt.
- Handshake on last_subkey → IDLE on the next cycle: subkey_valid=0, load_ready=1, last_subkey=0. subkey holds its last value.
- key_load while in RUN is ignored; there is no queueing.
- key_load in the same cycle as the final handshake is not accepted; load_ready is still 0 in that cycle.
- Mode changes on decrypt mid-sequence have no effect.
- No arithmetic beyond the 4-bit round counter. The counter never wraps inside a sequence.

Decomposition:
- Package des_pkg holds:
  - PC1 table [0:55] of 6-bit indices;
  - PC2 table [0:47] of 6-bit indices;
  - SHIFT_SCHEDULE [0:15] of 2-bit values;
  - typedefs half_key_t [0:27], subkey_t [0:47], des_key_t [0:63];
  - enum ks_state_t {IDLE, RUN}.
- Sub-module des_pc2_select: combinational, C/D in, 48-bit subkey out, generate-loop wiring from PC2. It is reusable by the encrypt path.
- PC-1 and the rotate logic stay inline in the top.

Test Plan:
- Reset, then encrypt load of key 0x133457799BBCDFF1 with subkey_ready=1 → 16 consecutive valid cycles starting 1 cycle after load:
  - K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, ..., K15=0xBF918D3D3F0A, K16=0xCB3D8B0E17F5;
  - last_subkey only with K16; load_ready=1 the following cycle.
- Same key, decrypt=1 → first subkey 0xCB3D8B0E17F5 with round_idx=15, second 0xBF918D3D3F0A, ..., last 0x1B02EFFC7072 with round_idx=0 and last_subkey=1.
- Backpressure: decrypt sequence with subkey_ready toggled pseudo-randomly → subkey and round_idx stable on every stalled cycle; exactly 16 handshakes; the sequence equals the reverse of the encrypt sequence.
- Parity insensitivity: key 0x123456789ABCDEF0 vs the same key with every parity bit flipped → identical 16-subkey sequences.
- key_load pulsed during RUN and on the final-handshake cycle → ignored; a new load is accepted only once load_ready=1.
- n_rst=0 asserted at round_idx=7 with subkey_ready=0 → next cycle subkey_valid=0, load_ready=1, round_idx=0; a fresh load restarts from K1.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule tables and types: PC-1/PC-2 (1-based DES bit numbers,
// MSB-first) and the per-round left-rotation schedule.
package des_pkg;

   typedef logic [0:27] half_key_t;
   typedef logic [0:47] subkey_t;
   typedef logic [0:63] des_key_t;

   typedef enum logic {IDLE, RUN} ks_state_t;

   localparam logic [5:0] PC1 [0:55] = '{
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
      6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
      6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
      6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
      6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   localparam logic [5:0] PC2 [0:47] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   localparam logic [1:0] SHIFT_SCHEDULE [0:15] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

endpackage

// File: rtl/des_pc2_select.sv
// PC-2 compression: selects the 48 round-subkey bits from the 56-bit C||D state.
module des_pc2_select
   import des_pkg::*;
(
   input  logic [0:27] c_i,
   input  logic [0:27] d_i,
   output logic [0:47] subkey_o
);

   logic [0:55] cd;
   assign cd = {c_i, d_i};

   for (genvar g = 0; g < 48; g++) begin : g_pc2
      assign subkey_o[g] = cd[PC2[g] - 6'd1];
   end

   // PC-2 drops these eight C||D positions.
   logic unused_cd_bits;
   assign unused_cd_bits = ^{cd[8], cd[17], cd[21], cd[24], cd[34], cd[37], cd[42], cd[53]};

endmodule

// File: rtl/des_key_schedule_bidir.sv
// Sequential DES subkey generator: K1..K16 (left rotations) or K16..K1 (right
// rotations), one subkey per valid/ready handshake.
module des_key_schedule_bidir
   import des_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 16
)
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic [0:63] key_in,
   input  logic        decrypt,
   input  logic        key_load,
   output logic        load_ready,
   output logic [0:47] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  round_idx,
   output logic        last_subkey
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

   ks_state_t  state_q, state_d;
   half_key_t  c_q, c_d, d_q, d_d;
   logic       mode_q, mode_d;
   logic [3:0] round_q, round_d;
   subkey_t    subkey_q, subkey_d;

   function automatic half_key_t rot(input half_key_t h, input logic [1:0] amt,
                                     input logic right);
      case (amt)
         2'd1:    return right ? {h[27], h[0:26]}    : {h[1:27], h[0]};
         2'd2:    return right ? {h[26:27], h[0:25]} : {h[2:27], h[0:1]};
         default: return h;
      endcase
   endfunction

   logic [0:55] pc1_key;
   for (genvar g = 0; g < 56; g++) begin : g_pc1
      assign pc1_key[g] = key_in[PC1[g] - 6'd1];
   end

   logic unused_parity;
   assign unused_parity = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                            key_in[39], key_in[47], key_in[55], key_in[63]};

   assign load_ready   = (state_q == IDLE);
   assign subkey_valid = (state_q == RUN);
   assign round_idx    = round_q;
   assign subkey       = subkey_q;
   assign last_subkey  = subkey_valid && (mode_q ? (round_q == '0) : (round_q == LAST_ROUND));

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      mode_d  = mode_q;
      round_d = round_q;
      unique case (state_q)
         IDLE: begin
            if (key_load) begin
               // Decrypt starts unrotated: C0/D0 equals C16/D16 after 28 total shifts.
               state_d = RUN;
               mode_d  = decrypt;
               c_d     = rot(pc1_key[0:27],  decrypt ? 2'd0 : SHIFT_SCHEDULE[0], 1'b0);
               d_d     = rot(pc1_key[28:55], decrypt ? 2'd0 : SHIFT_SCHEDULE[0], 1'b0);
               round_d = decrypt ? LAST_ROUND : '0;
            end
         end
         RUN: begin
            if (subkey_ready) begin
               if (last_subkey) begin
                  state_d = IDLE;
               end else if (mode_q) begin
                  c_d     = rot(c_q, SHIFT_SCHEDULE[round_q], 1'b1);
                  d_d     = rot(d_q, SHIFT_SCHEDULE[round_q], 1'b1);
                  round_d = round_q - 4'd1;
               end else begin
                  c_d     = rot(c_q, SHIFT_SCHEDULE[round_q + 4'd1], 1'b0);
                  d_d     = rot(d_q, SHIFT_SCHEDULE[round_q + 4'd1], 1'b0);
                  round_d = round_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   des_pc2_select u_pc2 (
      .c_i      (c_d),
      .d_i      (d_d),
      .subkey_o (subkey_d)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         c_q      <= '0;
         d_q      <= '0;
         mode_q   <= 1'b0;
         round_q  <= '0;
         subkey_q <= '0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         d_q      <= d_d;
         mode_q   <= mode_d;
         round_q  <= round_d;
         subkey_q <= subkey_d;
      end
   end

endmodule

// File: tb/tb_des_key_schedule_bidir.sv
// Self-checking bench for des_key_schedule_bidir: cumulative-rotation model plus
// literal subkey values for the classic 0x133457799BBCDFF1 key.
module tb_des_key_schedule_bidir;
   import des_pkg::*;

   localparam logic [0:63] KEY_A  = 64'h133457799BBCDFF1;
   localparam logic [0:63] KEY_P  = 64'h123456789ABCDEF0;
   localparam logic [0:63] PAR_FL = 64'h0101010101010101;
   localparam logic [0:63] DECOY  = 64'hFEDCBA9876543210;
   localparam logic [0:47] K1  = 48'h1B02EFFC7072;
   localparam logic [0:47] K2  = 48'h79AED9DBC9E5;
   localparam logic [0:47] K15 = 48'hBF918D3D3F0A;
   localparam logic [0:47] K16 = 48'hCB3D8B0E17F5;

   logic        clk, n_rst, decrypt, key_load, subkey_ready;
   logic [0:63] key_in;
   logic        load_ready, subkey_valid, last_subkey;
   logic [0:47] subkey;
   logic [3:0]  round_idx;

   des_key_schedule_bidir #(.NUM_ROUNDS(16)) dut (
      .clk(clk), .n_rst(n_rst), .key_in(key_in), .decrypt(decrypt),
      .key_load(key_load), .load_ready(load_ready), .subkey(subkey),
      .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
      .round_idx(round_idx), .last_subkey(last_subkey)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [0:47] hs_log [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ki from first principles: PC-2 of C0/D0 rotated left by the cumulative shift count.
   function automatic logic [0:47] model_subkey(input logic [0:63] key, input int r);
      logic [0:27] c, d;
      logic [0:55] cd;
      logic [0:47] res;
      int total = 0;
      for (int i = 0; i < 28; i++) begin
         c[i] = key[PC1[i] - 1];
         d[i] = key[PC1[i + 28] - 1];
      end
      for (int j = 0; j <= r; j++) total += int'(SHIFT_SCHEDULE[j]);
      repeat (total % 28) begin
         c = {c[1:27], c[0]};
         d = {d[1:27], d[0]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) res[i] = cd[PC2[i] - 1];
      return res;
   endfunction

   // Compare process state
   bit          known = 0, exp_active = 0, exp_mode = 0, after_rst = 0, prev_stall = 0;
   logic [0:63] exp_key = '0;
   int          cnt = 0, r;
   logic [0:47] idle_subkey = '0, prev_subkey = '0;
   logic [3:0]  prev_round = '0;

   always @(negedge clk) begin
      r = exp_mode ? 15 - cnt : cnt;
      if (known) begin
         check("load_ready", 64'(load_ready), 64'(!exp_active));
         check("subkey_valid", 64'(subkey_valid), 64'(exp_active));
         if (exp_active) begin
            check("round_idx", 64'(round_idx), 64'(r));
            check("subkey", 64'(subkey), 64'(model_subkey(exp_key, r)));
            check("last_subkey", 64'(last_subkey), 64'(cnt == 15));
         end else begin
            check("idle_subkey", 64'(subkey), 64'(idle_subkey));
            check("idle_last", 64'(last_subkey), 64'(0));
            if (after_rst) check("rst_round", 64'(round_idx), 64'(0));
         end
         if (prev_stall) begin
            check("stall_subkey", 64'(subkey), 64'(prev_subkey));
            check("stall_round", 64'(round_idx), 64'(prev_round));
         end
      end
      prev_stall  = n_rst && subkey_valid && !subkey_ready;
      prev_subkey = subkey;
      prev_round  = round_idx;
      if (n_rst && subkey_valid && subkey_ready) hs_log.push_back(subkey);
      if (!n_rst) begin
         known = 1; exp_active = 0; after_rst = 1; idle_subkey = '0; cnt = 0;
      end else if (known) begin
         if (exp_active) begin
            if (subkey_ready) begin
               if (cnt == 15) begin
                  exp_active  = 0;
                  idle_subkey = model_subkey(exp_key, r);
               end else cnt++;
            end
         end else if (key_load) begin
            exp_active = 1; exp_mode = decrypt; exp_key = key_in; cnt = 0; after_rst = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_seq(input logic [0:63] key, input logic dec, input bit rnd,
                          input bit load_during, output logic [0:47] seq [16]);
      int start;
      bit done = 0;
      start = hs_log.size();
      key_in = key; decrypt = dec; key_load = 1'b1; subkey_ready = 1'b1;
      tick();
      decrypt = ~dec;
      if (load_during) key_in = DECOY;
      else key_load = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (hs_log.size() - start >= 16) begin done = 1; break; end
         subkey_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
         tick();
      end
      key_load = 1'b0; subkey_ready = 1'b1; decrypt = 1'b0;
      if (!done) check("seq_timeout", 64'(hs_log.size() - start), 64'(16));
      tick(); tick();
      check("hs_count", 64'(hs_log.size() - start), 64'(16));
      for (int i = 0; i < 16; i++)
         seq[i] = (start + i < hs_log.size()) ? hs_log[start + i] : '0;
   endtask

   logic [0:47] enc [16], dec1 [16], dec2 [16], pa [16], pb [16], seq_x [16];

   initial begin
      n_rst = 1'b0; key_load = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1; key_in = '0;
      tick(); tick();
      n_rst = 1'b1;
      tick();

      check("model_K1",  64'(model_subkey(KEY_A, 0)),  64'(K1));
      check("model_K16", 64'(model_subkey(KEY_A, 15)), 64'(K16));

      run_seq(KEY_A, 1'b0, 0, 0, enc);
      check("enc_K1",  64'(enc[0]),  64'(K1));
      check("enc_K2",  64'(enc[1]),  64'(K2));
      check("enc_K15", 64'(enc[14]), 64'(K15));
      check("enc_K16", 64'(enc[15]), 64'(K16));

      run_seq(KEY_A, 1'b1, 0, 0, dec1);
      check("dec_first",  64'(dec1[0]),  64'(K16));
      check("dec_second", 64'(dec1[1]),  64'(K15));
      check("dec_last",   64'(dec1[15]), 64'(K1));

      run_seq(KEY_A, 1'b1, 1, 0, dec2);
      for (int i = 0; i < 16; i++) check("bp_reverse", 64'(dec2[i]), 64'(enc[15 - i]));

      run_seq(KEY_P, 1'b0, 1, 0, pa);
      run_seq(KEY_P ^ PAR_FL, 1'b0, 1, 0, pb);
      for (int i = 0; i < 16; i++) check("parity", 64'(pb[i]), 64'(pa[i]));

      run_seq(KEY_A, 1'b0, 0, 1, seq_x);
      check("ldrun_K1",  64'(seq_x[0]),  64'(K1));
      check("ldrun_K16", 64'(seq_x[15]), 64'(K16));
      run_seq(DECOY, 1'b0, 0, 0, seq_x);
      check("reload_K1", 64'(seq_x[0]), 64'(model_subkey(DECOY, 0)));

      // Reset in the middle of a sequence while stalled at round 7
      key_in = KEY_A; decrypt = 1'b0; key_load = 1'b1; subkey_ready = 1'b1;
      tick();
      key_load = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (round_idx == 4'd7) break;
         tick();
      end
      check("at_round7", 64'(round_idx), 64'(7));
      subkey_ready = 1'b0;
      tick();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1; subkey_ready = 1'b1;
      check("mid_rst_valid", 64'(subkey_valid), 64'(0));
      check("mid_rst_ready", 64'(load_ready), 64'(1));
      check("mid_rst_round", 64'(round_idx), 64'(0));
      tick(); tick();
      run_seq(KEY_A, 1'b0, 0, 0, seq_x);
      check("post_rst_K1", 64'(seq_x[0]), 64'(K1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
